// File: rtl/dummy_ap_ctrl_chain.sv
// ---------------------------------------------------------------------------
// DummyApCtrlChain (module dummy_ap_ctrl_chain)
//
// Purpose:
//   A small register file behind an HLS-style ap_ctrl_chain handshake.
//   Each accepted start latches an address, write data and a read/write
//   select. The block then waits LATENCY enabled cycles, performs the access
//   and presents the result on ap_return. ap_done stays high until the
//   downstream side acknowledges it with ap_continue.
//
// Parameters:
//   LATENCY  cycles from start acceptance to ap_done (1..8)
//   NREGS    number of 32-bit storage registers (power of two, 2..256)
//
// Ports:
//   clk          rising-edge clock for all state
//   ap_rst       asynchronous reset, active-low (0 = reset)
//   addr         byte address; the word index is addr[31:2]
//   wr_data      write data
//   rd_wr        1 = read, 0 = write
//   ap_start     request a transaction
//   ap_continue  downstream acknowledge of ap_done
//   ap_ce        clock enable; 0 freezes all state
//   ap_return    transaction result
//   ap_idle      high while no transaction is in progress
//   ap_ready     combinational pulse in the cycle a start is accepted
//   ap_done      transaction complete, held until acknowledged
// ---------------------------------------------------------------------------
module dummy_ap_ctrl_chain #(
    parameter int LATENCY = 3,
    parameter int NREGS   = 16
) (
    input  logic        clk,
    input  logic        ap_rst,
    input  logic [31:0] addr,
    input  logic [31:0] wr_data,
    input  logic        rd_wr,
    input  logic        ap_start,
    input  logic        ap_continue,
    input  logic        ap_ce,
    output logic [31:0] ap_return,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic        ap_done
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;
    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [29:0]      wordIdx_q;
    logic [31:0]      wrData_q;
    logic             rdWr_q;
    logic [31:0]      regs_q [NREGS];
    logic [31:0]      return_q, return_d;

    logic             accept;
    logic             execute;
    logic             inRange;
    logic [31:0]      readData;
    logic             unusedAddrLsb;

    // The byte-lane bits of the address carry no meaning for a word-wide
    // register file; they are folded into a deliberately unused signal.
    assign unusedAddrLsb = ^addr[1:0];

    // A start is accepted only from IDLE with the clock enabled. Gating with
    // ap_rst keeps ap_ready low while reset holds the FSM in IDLE.
    assign accept  = ap_rst && ap_ce && ap_start && (state_q == S_IDLE);

    // The access happens on the enabled edge where the BUSY countdown
    // has reached zero.
    assign execute = ap_ce && (state_q == S_BUSY) && (cnt_q == '0);

    // The full 30-bit word index is compared, so indices that would alias
    // onto a real register after truncation are treated as out of range.
    assign inRange  = (wordIdx_q < 30'(NREGS));
    assign readData = regs_q[wordIdx_q[IDX_W-1:0]];

    // Next-state logic for the FSM, the countdown and the result register.
    // With ap_ce low, every *_d simply equals its *_q.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        return_d = return_q;
        if (ap_ce) begin
            case (state_q)
                S_IDLE: begin
                    if (ap_start) begin
                        state_d = S_BUSY;
                        cnt_d   = CNT_LOAD;
                    end
                end
                S_BUSY: begin
                    if (cnt_q == '0) begin
                        state_d = S_DONE;
                        if (!inRange) begin
                            return_d = '0;
                        end else if (rdWr_q) begin
                            return_d = readData;
                        end else begin
                            return_d = wrData_q;
                        end
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (ap_continue) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // Control state: FSM, countdown and the result register.
    always_ff @(posedge clk or negedge ap_rst) begin
        if (!ap_rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            return_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            return_q <= return_d;
        end
    end

    // Transaction operands are captured at the accepting edge and stay
    // stable for the whole BUSY/DONE phase.
    always_ff @(posedge clk or negedge ap_rst) begin
        if (!ap_rst) begin
            wordIdx_q <= '0;
            wrData_q  <= '0;
            rdWr_q    <= 1'b0;
        end else if (accept) begin
            wordIdx_q <= addr[31:2];
            wrData_q  <= wr_data;
            rdWr_q    <= rd_wr;
        end
    end

    // Storage registers. Writes commit only at the execute edge, so a
    // reset during BUSY or DONE leaves no trace of the aborted write.
    always_ff @(posedge clk or negedge ap_rst) begin
        if (!ap_rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (execute && !rdWr_q && inRange) begin
            regs_q[wordIdx_q[IDX_W-1:0]] <= wrData_q;
        end
    end

    assign ap_idle   = (state_q == S_IDLE);
    assign ap_done   = (state_q == S_DONE);
    assign ap_ready  = accept;
    assign ap_return = return_q;

endmodule

// File: tb/tb_dummy_ap_ctrl_chain.sv
// ---------------------------------------------------------------------------
// Testbench for dummy_ap_ctrl_chain.
// Directed transactions push their hand-computed ap_return into a queue.
// A monitor process pops one entry on every rising ap_done and compares it.
// The stimulus tasks also check handshake timing: ap_ready, the latency to
// ap_done, the done pulse width, stalls, and clock-enable freezes.
// ---------------------------------------------------------------------------
module tb_dummy_ap_ctrl_chain;

    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        ap_rst;
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic        rd_wr;
    logic        ap_start;
    logic        ap_continue;
    logic        ap_ce;
    logic [31:0] ap_return;
    logic        ap_idle;
    logic        ap_ready;
    logic        ap_done;

    int          total = 0;
    int          bad = 0;
    logic [31:0] expQ[$];
    logic [31:0] expVal;
    logic        prevDone = 1'b0;

    dummy_ap_ctrl_chain #(
        .LATENCY(LAT),
        .NREGS  (16)
    ) dut (
        .clk        (clk),
        .ap_rst     (ap_rst),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_wr      (rd_wr),
        .ap_start   (ap_start),
        .ap_continue(ap_continue),
        .ap_ce      (ap_ce),
        .ap_return  (ap_return),
        .ap_idle    (ap_idle),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: one expected result per rising ap_done.
    always @(negedge clk) begin
        if (!ap_rst) begin
            prevDone = 1'b0;
        end else begin
            if (ap_done && !prevDone) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL scoreboard: unexpected ap_done with ap_return=0x%08h, nothing queued", ap_return);
                end else begin
                    expVal = expQ.pop_front();
                    checkOutput("scoreboard ap_return", ap_return, expVal);
                end
            end
            prevDone = ap_done;
        end
    end

    // Run one transaction. ceGap drops ap_ce for that many cycles right
    // after acceptance. holdCycles > 0 keeps ap_continue low for that many
    // cycles after done, while issuing starts that must be ignored.
    task automatic applyStimulus(input string name, input logic rw, input logic [31:0] a,
                                 input logic [31:0] d, input logic [31:0] expRet,
                                 input int ceGap, input int holdCycles);
        int   n;
        logic holdOk;
        @(negedge clk);
        expQ.push_back(expRet);
        addr        = a;
        wr_data     = d;
        rd_wr       = rw;
        ap_start    = 1'b1;
        ap_ce       = 1'b1;
        ap_continue = (holdCycles == 0);
        #1;
        checkOutput({name, " ready on start"}, 32'(ap_ready), 32'd1);
        @(negedge clk);
        ap_start = 1'b0;
        checkOutput({name, " idle low in busy"}, 32'(ap_idle), 32'd0);
        n = 0;
        while (!ap_done && n < 60) begin
            ap_ce = (n < ceGap) ? 1'b0 : 1'b1;
            @(negedge clk);
            n++;
        end
        ap_ce = 1'b1;
        checkOutput({name, " done latency"}, 32'(n), 32'(LAT + ceGap));
        if (holdCycles == 0) begin
            @(negedge clk);
            checkOutput({name, " done one cycle"}, 32'(ap_done), 32'd0);
            checkOutput({name, " idle after done"}, 32'(ap_idle), 32'd1);
        end else begin
            holdOk = 1'b1;
            for (int i = 0; i < holdCycles; i++) begin
                ap_start = (i < holdCycles - 1);
                addr     = 32'h4;
                rd_wr    = ~rw;
                wr_data  = ~d;
                #1;
                if (ap_ready !== 1'b0) holdOk = 1'b0;
                @(negedge clk);
                if (ap_done !== 1'b1 || ap_return !== expRet || ap_idle !== 1'b0) holdOk = 1'b0;
            end
            checkOutput({name, " stable while stalled"}, 32'(holdOk), 32'd1);
            ap_start    = 1'b0;
            ap_continue = 1'b1;
            @(negedge clk);
            checkOutput({name, " idle after continue"}, 32'(ap_idle), 32'd1);
            checkOutput({name, " done cleared"}, 32'(ap_done), 32'd0);
        end
    endtask

    initial begin
        ap_rst      = 1'b1;
        addr        = '0;
        wr_data     = '0;
        rd_wr       = 1'b0;
        ap_start    = 1'b1;
        ap_continue = 1'b1;
        ap_ce       = 1'b1;
        #1 ap_rst = 1'b0;
        #1;
        checkOutput("reset idle", 32'(ap_idle), 32'd1);
        checkOutput("reset done", 32'(ap_done), 32'd0);
        checkOutput("reset ready with start high", 32'(ap_ready), 32'd0);
        checkOutput("reset return", ap_return, 32'h0);
        checkOutput("reset no X", 32'($isunknown({ap_return, ap_idle, ap_ready, ap_done})), 32'd0);
        ap_start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        ap_rst = 1'b1;

        applyStimulus("wr0",          1'b0, 32'h0000_0000, 32'h0000_7216, 32'h0000_7216, 0, 0);
        applyStimulus("rd0",          1'b1, 32'h0000_0000, 32'h0,         32'h0000_7216, 0, 0);
        applyStimulus("rd4",          1'b1, 32'h0000_0004, 32'h0,         32'h0,         0, 0);
        applyStimulus("wrFFFFFFFF",   1'b0, 32'hFFFF_FFFF, 32'h0000_0055, 32'h0,         0, 0);
        applyStimulus("rdFFFFFFFF",   1'b1, 32'hFFFF_FFFF, 32'h0,         32'h0,         0, 0);
        applyStimulus("rd0 intact",   1'b1, 32'h0000_0000, 32'h0,         32'h0000_7216, 0, 0);
        applyStimulus("rd3 lsb",      1'b1, 32'h0000_0003, 32'h0,         32'h0000_7216, 0, 0);
        applyStimulus("wr3C",         1'b0, 32'h0000_003C, 32'h1234_5678, 32'h1234_5678, 0, 0);
        applyStimulus("rd3C",         1'b1, 32'h0000_003C, 32'h0,         32'h1234_5678, 0, 0);
        applyStimulus("wr40",         1'b0, 32'h0000_0040, 32'h0000_0099, 32'h0,         0, 0);
        applyStimulus("rd40",         1'b1, 32'h0000_0040, 32'h0,         32'h0,         0, 0);
        applyStimulus("rd0 no alias", 1'b1, 32'h0000_0000, 32'h0,         32'h0000_7216, 0, 0);
        applyStimulus("wr14 ce gap",  1'b0, 32'h0000_0014, 32'hCAFE_F00D, 32'hCAFE_F00D, 5, 0);
        applyStimulus("rd14 stall",   1'b1, 32'h0000_0014, 32'h0,         32'hCAFE_F00D, 0, 20);

        // Abort a write with reset while BUSY.
        @(negedge clk);
        addr        = 32'h0000_0008;
        wr_data     = 32'h0000_ABCD;
        rd_wr       = 1'b0;
        ap_start    = 1'b1;
        ap_continue = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        checkOutput("abort busy before reset", 32'(ap_idle), 32'd0);
        @(posedge clk);
        #2 ap_rst = 1'b0;
        #1;
        checkOutput("abort idle", 32'(ap_idle), 32'd1);
        checkOutput("abort done", 32'(ap_done), 32'd0);
        checkOutput("abort ready", 32'(ap_ready), 32'd0);
        checkOutput("abort return", ap_return, 32'h0);
        @(negedge clk);
        @(negedge clk);
        ap_rst = 1'b1;
        repeat (LAT + 2) @(negedge clk);
        checkOutput("abort stays idle", 32'(ap_idle), 32'd1);

        applyStimulus("rd8 after abort", 1'b1, 32'h0000_0008, 32'h0, 32'h0, 0, 0);
        applyStimulus("rd0 after abort", 1'b1, 32'h0000_0000, 32'h0, 32'h0, 0, 0);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
